mpsoc_trace_terminator: RTL and testbench

Parametrised run-control monitor for multi-tile OR1K MPSoC systems. It watches the retired-instruction trace of every core and decodes the simulation l.nop conventions: exit, report and putc. It tracks per-core termination, a global done/fail verdict and an inactivity watchdog. Every decoded event is serialised into one buffered valid/ready stream, which feeds the host/debug channel. The block supersedes the fixed per-core termination wiring and scales to any core count.

---
 rtl/mpsoc_trace_terminator_if.sv | 27 ++
 rtl/mpsoc_trace_terminator.sv | 174 +++++++++++++++++
 tb/tb_mpsoc_trace_terminator.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpsoc_trace_terminator_if.sv
// Bundle between the trace terminator and its environment: per-core retire
// trace in, sticky run-control status and the serialised event stream out.
interface mpsoc_trace_terminator_if #(
  parameter int NUM_CORES = 4
);
  logic [NUM_CORES-1:0]    trace_valid;
  logic [NUM_CORES*32-1:0] trace_insn;
  logic [NUM_CORES*32-1:0] trace_r3;
  logic [NUM_CORES-1:0]    term;
  logic                    all_done;
  logic                    fail;
  logic                    timeout;
  logic                    overflow;
  logic                    evt_valid;
  logic [41:0]             evt_data;
  logic                    evt_ready;

  modport master (
    output trace_valid, trace_insn, trace_r3, evt_ready,
    input  term, all_done, fail, timeout, overflow, evt_valid, evt_data
  );

  modport slave (
    input  trace_valid, trace_insn, trace_r3, evt_ready,
    output term, all_done, fail, timeout, overflow, evt_valid, evt_data
  );
endinterface

// File: rtl/mpsoc_trace_terminator.sv
// Run-control monitor: decodes l.nop exit/report/putc from every core's retire
// trace, keeps termination/fail/watchdog status and serialises events into a FIFO.
module mpsoc_trace_terminator #(
  parameter int          NUM_CORES  = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 0,
  parameter logic [15:0] NOP_EXIT   = 16'h0001,
  parameter logic [15:0] NOP_REPORT = 16'h0002,
  parameter logic [15:0] NOP_PUTC   = 16'h0004
) (
  input  logic                      clk,
  input  logic                      rst,
  mpsoc_trace_terminator_if.slave   bus
);

  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef logic [41:0] evt_t;

  logic [NUM_CORES-1:0] term_reg;
  logic [NUM_CORES-1:0] live;
  logic [NUM_CORES-1:0] evt_hit;
  logic [NUM_CORES-1:0] exit_hit;
  logic [NUM_CORES-1:0] exit_fail;
  logic [NUM_CORES-1:0] grant;
  logic [NUM_CORES-1:0] drop;
  evt_t                 evt_word [NUM_CORES];

  logic [NUM_CORES-1:0] slot_full_reg;
  evt_t                 slot_data_reg [NUM_CORES];
  logic [CW-1:0]        ptr_reg;
  logic [CW-1:0]        sel_idx;
  logic                 sel_valid;

  logic                 all_done_reg;
  logic                 fail_reg;
  logic                 overflow_reg;
  logic                 timeout_reg;

  evt_t                 fifo_mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_reg;
  logic [AW:0]          rd_ptr_reg;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;

  // Per-core decode; a terminated core's trace is invisible to everything.
  for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_dec
    logic [7:0]  opcode;
    logic [7:0]  unused_mid;
    logic [15:0] imm;
    logic [31:0] r3;
    logic        is_nop;
    logic        is_exit;
    logic        is_report;
    logic        is_putc;

    assign opcode     = bus.trace_insn[32*gi+24 +: 8];
    assign unused_mid = bus.trace_insn[32*gi+16 +: 8];
    assign imm        = bus.trace_insn[32*gi +: 16];
    assign r3         = bus.trace_r3[32*gi +: 32];
    assign is_nop     = (opcode == 8'h15);
    assign is_exit    = is_nop && (imm == NOP_EXIT);
    assign is_report  = is_nop && (imm == NOP_REPORT);
    assign is_putc    = is_nop && (imm == NOP_PUTC);

    assign live[gi]      = bus.trace_valid[gi] & ~term_reg[gi];
    assign exit_hit[gi]  = live[gi] & is_exit;
    assign exit_fail[gi] = exit_hit[gi] & (r3 != 32'h0);
    assign evt_hit[gi]   = live[gi] & (is_exit | is_report | is_putc);
    assign evt_word[gi]  = is_exit   ? {2'b00, 8'(gi), r3} :
                           is_report ? {2'b01, 8'(gi), r3} :
                                       {2'b10, 8'(gi), 24'h0, r3[7:0]};

    // A slot granted this cycle frees up in time to take the new event.
    assign grant[gi] = push && (sel_idx == CW'(gi));
    assign drop[gi]  = evt_hit[gi] & slot_full_reg[gi] & ~grant[gi];
  end

  // Round-robin pick: first full slot after the last granted core.
  always_comb begin
    logic [CW:0] idx;
    sel_valid = 1'b0;
    sel_idx   = '0;
    idx       = '0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      idx = {1'b0, ptr_reg} + (CW+1)'(i);
      if (idx >= (CW+1)'(NUM_CORES)) begin
        idx = idx - (CW+1)'(NUM_CORES);
      end
      if (!sel_valid && slot_full_reg[idx[CW-1:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = idx[CW-1:0];
      end
    end
  end

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                      (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
  assign pop        = ~fifo_empty & bus.evt_ready;
  assign push       = sel_valid & (~fifo_full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_reg      <= '0;
      all_done_reg  <= 1'b0;
      fail_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
      slot_full_reg <= '0;
      ptr_reg       <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
    end else begin
      term_reg      <= term_reg | exit_hit;
      all_done_reg  <= &term_reg;
      fail_reg      <= fail_reg | (|exit_fail);
      overflow_reg  <= overflow_reg | (|drop);
      slot_full_reg <= (slot_full_reg & ~grant) | evt_hit;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
        ptr_reg    <= sel_idx;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Payload storage needs no reset: validity lives in the flags and pointers.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CORES; c++) begin
      if (evt_hit[c] && !drop[c]) begin
        slot_data_reg[c] <= evt_word[c];
      end
    end
    if (push) begin
      fifo_mem[wr_ptr_reg[AW-1:0]] <= slot_data_reg[sel_idx];
    end
  end

  if (TIMEOUT > 0) begin : g_wd
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wd_reg      <= '0;
        timeout_reg <= 1'b0;
      end else if (|live) begin
        wd_reg <= '0;
      end else if (!all_done_reg && !timeout_reg) begin
        if (wd_reg == WW'(TIMEOUT - 1)) begin
          timeout_reg <= 1'b1;
        end else begin
          wd_reg <= wd_reg + 1'b1;
        end
      end
    end
  end else begin : g_no_wd
    assign timeout_reg = 1'b0;
  end

  assign bus.term      = term_reg;
  assign bus.all_done  = all_done_reg;
  assign bus.fail      = fail_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.timeout   = timeout_reg;
  assign bus.evt_valid = ~fifo_empty;
  assign bus.evt_data  = fifo_empty ? '0 : fifo_mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: tb/tb_mpsoc_trace_terminator.sv
// Directed plus randomised bench for mpsoc_trace_terminator, checked against a
// transaction-level model (event queue, per-core pending slots, idle counter).
module tb_mpsoc_trace_terminator;

  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int TMO   = 10;

  localparam logic [31:0] I_EXIT   = 32'h1500_0001;
  localparam logic [31:0] I_REPORT = 32'h1500_0002;
  localparam logic [31:0] I_PUTC   = 32'h1500_0004;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mpsoc_trace_terminator_if #(.NUM_CORES(N)) bus ();

  mpsoc_trace_terminator #(
    .NUM_CORES (N),
    .FIFO_DEPTH(DEPTH),
    .TIMEOUT   (TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [N-1:0] m_term;
  bit           m_fail, m_done, m_to, m_ovf;
  int           m_wd, m_ptr;
  bit           m_full [N];
  logic [41:0]  m_slot [N];
  logic [41:0]  q [$];
  logic [41:0]  got [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.trace_valid = '0;
  endtask

  task automatic put(input int c, input logic [31:0] insn, input logic [31:0] r3);
    bus.trace_valid[c]         = 1'b1;
    bus.trace_insn[32*c +: 32] = insn;
    bus.trace_r3[32*c +: 32]   = r3;
  endtask

  task automatic model_reset();
    m_term = '0; m_fail = 0; m_done = 0; m_to = 0; m_ovf = 0;
    m_wd = 0; m_ptr = 0;
    for (int c = 0; c < N; c++) begin
      m_full[c] = 0;
      m_slot[c] = '0;
    end
    q.delete();
  endtask

  task automatic check_all();
    chk("evt_valid", bus.evt_valid, q.size() > 0);
    if (q.size() > 0) chk("evt_data", bus.evt_data, q[0]);
    chk("term", bus.term, m_term);
    chk("all_done", bus.all_done, m_done);
    chk("fail", bus.fail, m_fail);
    chk("timeout", bus.timeout, m_to);
    chk("overflow", bus.overflow, m_ovf);
  endtask

  // Advance the model by one clock from the currently driven inputs, then
  // let the DUT take the same edge and compare.
  task automatic cycle();
    logic [N-1:0] n_term;
    bit n_fail, n_ovf, n_to, n_done, pop, push, live_any;
    int n_wd, sel;
    n_term = m_term; n_fail = m_fail; n_ovf = m_ovf; n_to = m_to; n_wd = m_wd;
    n_done = &m_term;
    pop = (q.size() > 0) && bus.evt_ready;
    sel = -1;
    for (int k = 1; k <= N; k++)
      if (sel < 0 && m_full[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
    push = (sel >= 0) && ((q.size() < DEPTH) || pop);
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(m_slot[sel]);
      m_full[sel] = 0;
      m_ptr = sel;
    end
    live_any = 0;
    for (int c = 0; c < N; c++) begin
      if (bus.trace_valid[c] && !m_term[c]) begin
        logic [31:0] insn, r3;
        int ty;
        insn = bus.trace_insn[32*c +: 32];
        r3   = bus.trace_r3[32*c +: 32];
        live_any = 1;
        ty = -1;
        if (insn[31:24] == 8'h15) begin
          case (insn[15:0])
            16'h0001: ty = 0;
            16'h0002: ty = 1;
            16'h0004: ty = 2;
            default:  ty = -1;
          endcase
        end
        if (ty >= 0) begin
          if (m_full[c]) n_ovf = 1;
          else begin
            m_full[c] = 1;
            m_slot[c] = {2'(ty), 8'(c), (ty == 2) ? {24'h0, r3[7:0]} : r3};
          end
          if (ty == 0) begin
            n_term[c] = 1'b1;
            if (r3 != 0) n_fail = 1;
          end
        end
      end
    end
    if (live_any) n_wd = 0;
    else if (!m_done && !m_to) begin
      if (m_wd == TMO - 1) n_to = 1;
      else n_wd = m_wd + 1;
    end
    m_term = n_term; m_fail = n_fail; m_ovf = n_ovf; m_to = n_to; m_wd = n_wd;
    m_done = n_done;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_evt_valid", bus.evt_valid, 1'b0);
    chk("rst_evt_data", bus.evt_data, 42'h0);
    chk("rst_term", bus.term, 4'b0000);
    chk("rst_overflow", bus.overflow, 1'b0);
    chk("rst_status", {bus.all_done, bus.fail, bus.timeout}, 3'b000);
    idle();
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();
  endtask

  task automatic collect(input int ncyc);
    got.delete();
    for (int i = 0; i < ncyc; i++) begin
      if (bus.evt_valid) got.push_back(bus.evt_data);
      cycle();
    end
  endtask

  function automatic logic [31:0] rand_insn();
    int k;
    logic [7:0] mid;
    k = $urandom_range(0, 9);
    mid = 8'($urandom);
    case (k)
      0:       return {8'h15, mid, 16'h0001};
      1, 2, 3: return {8'h15, mid, 16'h0002};
      4, 5, 6: return {8'h15, mid, 16'h0004};
      7:       return {8'h15, mid, 16'h0008};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL global_time_limit: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.trace_valid = '0;
    bus.trace_insn  = '0;
    bus.trace_r3    = '0;
    bus.evt_ready   = 1'b1;
    model_reset();
    #1;
    do_reset();

    // Clean exit on core 2: term next edge, event two edges after retire.
    put(2, I_EXIT, 32'h0); cycle(); idle();
    chk("exit_term", bus.term, 4'b0100);
    chk("exit_not_yet", bus.evt_valid, 1'b0);
    cycle();
    chk("exit_evt_valid", bus.evt_valid, 1'b1);
    chk("exit_evt_data", bus.evt_data, {2'b00, 8'd2, 32'h0});
    chk("exit_fail", bus.fail, 1'b0);

    // Failing exit, then the remaining cores; all_done lags by one edge.
    put(1, I_EXIT, 32'h5); cycle(); idle();
    chk("fail_set", bus.fail, 1'b1);
    put(0, I_EXIT, 32'h0); put(3, I_EXIT, 32'h0); cycle(); idle();
    chk("all_term", bus.term, 4'b1111);
    chk("all_done_lag", bus.all_done, 1'b0);
    cycle();
    chk("all_done_rise", bus.all_done, 1'b1);
    repeat (6) cycle();

    // Park the arbiter pointer on core 3 so the next sweep starts at core 0.
    do_reset();
    put(3, I_PUTC, 32'h5A); cycle(); idle();
    repeat (3) cycle();
    for (int c = 0; c < N; c++) put(c, I_PUTC, 32'h100 + 32'h41 + c);
    cycle(); idle();
    collect(10);
    chk("putc_count", got.size(), 4);
    for (int k = 0; k < 4; k++)
      chk("putc_order", (k < got.size()) ? got[k] : '1, {2'b10, 8'(k), 32'(32'h41 + k)});

    // Backpressure: two in the FIFO, one parked in the slot, one dropped.
    do_reset();
    bus.evt_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      put(0, I_REPORT, 32'(100 + r));
      cycle();
    end
    idle();
    repeat (2) cycle();
    chk("bp_overflow", bus.overflow, 1'b1);
    chk("bp_head", bus.evt_data, {2'b01, 8'd0, 32'd100});
    bus.evt_ready = 1'b1;
    collect(10);
    chk("bp_count", got.size(), 3);
    for (int k = 0; k < 3; k++)
      chk("bp_order", (k < got.size()) ? got[k] : '1, {2'b01, 8'd0, 32'(100 + k)});

    // Watchdog: one retire, then ten quiet edges to expiry.
    do_reset();
    repeat (4) cycle();
    put(1, 32'h1234_5678, 32'h0); cycle(); idle();
    for (int i = 1; i <= TMO - 1; i++) begin
      cycle();
      chk("wd_quiet", bus.timeout, 1'b0);
    end
    cycle();
    chk("wd_expire", bus.timeout, 1'b1);
    repeat (5) cycle();
    chk("wd_sticky", bus.timeout, 1'b1);

    do_reset();
    for (int c = 0; c < N; c++) put(c, I_EXIT, 32'h0);
    cycle(); idle();
    repeat (25) cycle();
    chk("wd_done_quiet", bus.timeout, 1'b0);
    chk("wd_done_flag", bus.all_done, 1'b1);

    // Reset with events queued and sticky flags set.
    do_reset();
    bus.evt_ready = 1'b0;
    put(0, I_REPORT, 32'h7); put(1, I_REPORT, 32'h8);
    put(2, I_PUTC, 32'h78); put(3, I_EXIT, 32'h0);
    cycle(); idle();
    cycle();
    put(0, I_REPORT, 32'h9); cycle(); idle();
    repeat (2) cycle();
    chk("mid_pre_valid", bus.evt_valid, 1'b1);
    chk("mid_pre_overflow", bus.overflow, 1'b1);
    do_reset();
    bus.evt_ready = 1'b1;
    repeat (5) cycle();
    chk("mid_post_empty", bus.evt_valid, 1'b0);

    // Randomised traffic against the model.
    for (int blk = 0; blk < 4; blk++) begin
      do_reset();
      for (int i = 0; i < 150; i++) begin
        bus.evt_ready = ($urandom_range(0, 3) != 0);
        idle();
        for (int c = 0; c < N; c++)
          if ($urandom_range(0, 2) == 0)
            put(c, rand_insn(), $urandom_range(0, 1) ? 32'h0 : 32'($urandom));
        cycle();
      end
      idle();
      bus.evt_ready = 1'b1;
      repeat (8) cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
